// File: rtl/cnn_pkg.sv
// Shared types for the CNN layer sequencer: layer-select codes, FSM states,
// default timing limits and state->code helpers.
package cnn_pkg;

  localparam int DEF_WDOG_CYCLES  = 1048576;
  localparam int DEF_GUARD_CYCLES = 2;

  typedef enum logic [7:0] {
    LC_IDLE  = 8'h00,
    LC_LOAD  = 8'h01,
    LC_CONV1 = 8'h02,
    LC_POOL1 = 8'h03,
    LC_CONV2 = 8'h04,
    LC_POOL2 = 8'h05,
    LC_FC    = 8'h06
  } layer_code_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CONV1, S_POOL1, S_CONV2, S_POOL2, S_FC, S_DONE, S_ERROR
  } seq_state_t;

  function automatic layer_code_t state_code(input seq_state_t s);
    case (s)
      S_LOAD:  return LC_LOAD;
      S_CONV1: return LC_CONV1;
      S_POOL1: return LC_POOL1;
      S_CONV2: return LC_CONV2;
      S_POOL2: return LC_POOL2;
      S_FC:    return LC_FC;
      default: return LC_IDLE;
    endcase
  endfunction

  function automatic seq_state_t next_layer(input seq_state_t s);
    case (s)
      S_LOAD:  return S_CONV1;
      S_CONV1: return S_POOL1;
      S_POOL1: return S_CONV2;
      S_CONV2: return S_POOL2;
      S_POOL2: return S_FC;
      S_FC:    return S_DONE;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cnn_seq_timer.sv
// Per-layer cycle counter: guard window after entry and watchdog expiry.
// cnt is 0 on the first cycle in a layer, so cycle n of the layer has cnt=n-1.
module cnn_seq_timer #(
  parameter int GUARD_CYCLES = 2,
  parameter int WDOG_CYCLES  = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic guard_done,
  output logic expired
);

  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (enable && cnt != '1)
      cnt <= cnt + 32'd1;
  end

  assign guard_done = (cnt >= 32'(GUARD_CYCLES));
  assign expired    = (cnt >= 32'(WDOG_CYCLES - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Steps a layer controller through LOAD..FC, handshaking on return_ctrl,
// with a per-layer watchdog, host abort and a saturating run-time counter.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int WDOG_CYCLES  = DEF_WDOG_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        img_ready,
  input  logic [7:0]  return_ctrl,
  output logic [7:0]  ctrl,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_layer,
  output logic [31:0] total_cycles
);

  seq_state_t state;
  seq_state_t nxt;
  logic in_run, in_layer, can_start;
  logic guard_done, expired;
  logic adv, wd, tmr_clear;

  assign in_layer  = state inside {S_CONV1, S_POOL1, S_CONV2, S_POOL2, S_FC};
  assign in_run    = in_layer || (state == S_LOAD);
  assign can_start = (state inside {S_IDLE, S_DONE, S_ERROR}) && start;
  assign nxt       = next_layer(state);

  // LOAD additionally waits for the host image; the watchdog never fires there
  assign adv = in_run && guard_done && (return_ctrl == state_code(state)) &&
               ((state != S_LOAD) || img_ready);
  assign wd  = in_layer && expired && !adv;

  // Every state change restarts the layer timer
  assign tmr_clear = abort || can_start || adv || wd;

  cnn_seq_timer #(
    .GUARD_CYCLES (GUARD_CYCLES),
    .WDOG_CYCLES  (WDOG_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (tmr_clear),
    .enable     (in_run),
    .guard_done (guard_done),
    .expired    (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ctrl         <= LC_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_layer    <= 3'd0;
      total_cycles <= '0;
    end else if (abort) begin
      // total_cycles deliberately held so the host can read partial run time
      state     <= S_IDLE;
      ctrl      <= LC_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_layer <= 3'd0;
    end else if (can_start) begin
      state        <= S_LOAD;
      ctrl         <= LC_LOAD;
      busy         <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_layer    <= 3'd0;
      total_cycles <= '0;
    end else if (in_run) begin
      if (total_cycles != '1)
        total_cycles <= total_cycles + 32'd1;
      if (adv) begin
        state <= nxt;
        ctrl  <= state_code(nxt);
        busy  <= (nxt != S_DONE);
        done  <= (nxt == S_DONE);
      end else if (wd) begin
        state     <= S_ERROR;
        ctrl      <= LC_IDLE;
        busy      <= 1'b0;
        error     <= 1'b1;
        err_layer <= ctrl[2:0];
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench: a per-run plan of expected output events is derived from
// layer latencies; a monitor pops and compares on every output change.
module tb_cnn_layer_sequencer;

  localparam int W = 64;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_m = 1'b0;
  logic        start_x = 1'b0;
  logic        abort = 1'b0;
  logic        img_ready = 1'b0;
  logic [7:0]  return_ctrl = 8'h00;
  logic [7:0]  ctrl;
  logic        busy, done, error;
  logic [2:0]  err_layer;
  logic [31:0] total_cycles;

  cnn_layer_sequencer #(.WDOG_CYCLES(W), .GUARD_CYCLES(G)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start_m | start_x),
    .abort        (abort),
    .img_ready    (img_ready),
    .return_ctrl  (return_ctrl),
    .ctrl         (ctrl),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_layer    (err_layer),
    .total_cycles (total_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  ctrl;
    logic        busy, done, error;
    logic [2:0]  err_layer;
    logic [31:0] total;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0, n_fail = 0;

  // Layer-controller model configuration (written only while ctrl is 0)
  int lat[1:6];
  int img_age = 0;
  bit noise = 1'b0;
  int abort_layer = 0, abort_age = 0;
  bit fc_start = 1'b0;
  bit mon_en = 1'b0;

  // Layer controller + host model: returns code k lat[k] cycles after ctrl=k
  initial begin : layer_model
    logic [7:0] cur;
    int age;
    cur = 8'h00;
    age = 0;
    forever begin
      @(negedge clk);
      if (ctrl !== cur) begin
        cur = ctrl;
        age = 0;
      end else begin
        age++;
      end
      abort   = 1'b0;
      start_x = 1'b0;
      if (cur == 8'h00) begin
        return_ctrl = 8'h00;
        img_ready   = 1'b0;
      end else if (cur inside {[8'h01:8'h06]}) begin
        if (cur == 8'h01 && age >= img_age) img_ready = 1'b1;
        if (age >= lat[cur]) return_ctrl = cur;
        else if (noise) return_ctrl = 8'h80 | 8'($urandom_range(0, 127));
        if (abort_layer == int'(cur) && age == abort_age) abort = 1'b1;
        if (fc_start && cur == 8'h06 && age == 3) start_x = 1'b1;
      end
    end
  end

  // Monitor: any change of ctrl/busy/done/error is an event to be matched
  initial begin : monitor
    logic [10:0] prev;
    ev_t e;
    prev = 11'd0;
    forever begin
      @(negedge clk);
      if (mon_en && ({ctrl, busy, done, error} !== prev)) begin
        prev = {ctrl, busy, done, error};
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event cyc=%0d ctrl=%h busy=%b done=%b error=%b",
                   cyc, ctrl, busy, done, error);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || ctrl !== e.ctrl || busy !== e.busy || done !== e.done ||
              error !== e.error || err_layer !== e.err_layer || total_cycles !== e.total) begin
            n_fail++;
            $display("FAIL event got cyc=%0d ctrl=%h b=%b d=%b e=%b el=%0d tot=%0d, expected cyc=%0d ctrl=%h b=%b d=%b e=%b el=%0d tot=%0d",
                     cyc, ctrl, busy, done, error, err_layer, total_cycles,
                     e.cyc, e.ctrl, e.busy, e.done, e.error, e.err_layer, e.total);
          end
        end
      end
    end
  end

  task automatic push(input int c, input int code, input bit b, input bit d,
                      input bit er, input int el, input int tot);
    ev_t e;
    e.cyc = c; e.ctrl = 8'(code); e.busy = b; e.done = d; e.error = er;
    e.err_layer = 3'(el); e.total = 32'(tot);
    exp_q.push_back(e);
  endtask

  // Expected events of one run whose LOAD is first visible on cycle p
  task automatic plan(input int p);
    int t, d;
    t = p;
    push(p, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      d = (lat[k] > G) ? lat[k] : G;
      if (k == 1 && img_age > d) d = img_age;
      if (abort_layer == k && abort_age <= d) begin
        push(t + abort_age + 1, 0, 0, 0, 0, 0, t + abort_age - p);
        return;
      end
      if (k >= 2 && d >= W) begin
        push(t + W, 0, 0, 0, 1, k, t + W - p);
        return;
      end
      t += d + 1;
      if (k < 6) push(t, k + 1, 1, 0, 0, 0, t - p);
      else       push(t, 0, 0, 1, 0, 0, t - p);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout pending=%0d expected=0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run(input string nm);
    int p;
    @(negedge clk);
    start_m = 1'b1;
    p = cyc + 1;
    plan(p);
    @(negedge clk);
    start_m = 1'b0;
    drain(nm);
  endtask

  task automatic cfg(input int l, input int ia, input bit nz);
    for (int k = 1; k <= 6; k++) lat[k] = l;
    img_age = ia; noise = nz; abort_layer = 0; abort_age = 0; fc_start = 1'b0;
  endtask

  initial begin
    int p;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 32'h0);
    chk("reset_flags", {29'd0, busy, done, error}, 32'h0);
    chk("reset_err_layer", 32'(err_layer), 32'h0);
    chk("reset_total", total_cycles, 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    cfg(10, 0, 0);
    run("nominal");
    chk("nominal_total", total_cycles, 32'd66);
    chk("nominal_done", 32'(done), 32'd1);

    cfg(0, 0, 0);
    run("guard_stale");

    cfg(10, 0, 0); lat[4] = 1000;
    run("watchdog");
    chk("wd_err_layer", 32'(err_layer), 32'd4);
    chk("wd_error", 32'(error), 32'd1);

    cfg(5, 0, 0); abort_layer = 3; abort_age = 5;
    run("abort_pool1");
    chk("abort_busy", 32'(busy), 32'd0);

    cfg(10, 0, 0); fc_start = 1'b1;
    run("start_in_fc");
    chk("start_fc_done", 32'(done), 32'd1);

    cfg(3, 0, 0); lat[6] = W - 1;
    run("adv_wd_coincide");
    chk("coincide_done", 32'(done), 32'd1);

    cfg(4, 3, 1); lat[2] = W;
    run("wd_boundary");

    // Reset in the middle of CONV1 also clears total_cycles
    cfg(30, 0, 0);
    @(negedge clk);
    start_m = 1'b1;
    p = cyc + 1;
    push(p, 1, 1, 0, 0, 0, 0);
    push(p + 31, 2, 1, 0, 0, 0, 31);
    @(negedge clk);
    start_m = 1'b0;
    while (cyc < p + 40) @(negedge clk);
    reset = 1'b1;
    push(p + 41, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drain("reset_mid");

    for (int i = 0; i < 12; i++) begin
      for (int k = 1; k <= 6; k++) lat[k] = $urandom_range(0, 12);
      img_age = $urandom_range(0, 5);
      noise = 1'($urandom_range(0, 1));
      abort_layer = 0; abort_age = 0; fc_start = 1'b0;
      if ($urandom_range(0, 3) == 0) lat[$urandom_range(2, 6)] = W - 1 + $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        abort_layer = $urandom_range(1, 6);
        abort_age = $urandom_range(0, 2);
      end
      run("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d expected_finish_before=100000", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 Parameter WDOG_CYCLES, default 1048576: per-layer watchdog limit in clk cycles.
REQ-002 Parameter GUARD_CYCLES, default 2: cycles after each layer entry during which return_ctrl is ignored.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  host request to run one inference; sampled in IDLE, DONE and ERROR only.
REQ-006 abort  input  1  host request to stop immediately; valid in every state.
REQ-007 img_ready  input  1  host level: image memory fully written.
REQ-008 return_ctrl  input  8  layer-complete code from the layer controller.
REQ-009 ctrl  output  8  layer-select code to the layer controller.
REQ-010 busy  output  1  high in LOAD through FC.
REQ-011 done  output  1  high while in DONE.
REQ-012 error  output  1  high while in ERROR.
REQ-013 err_layer  output  3  code of the layer that timed out; 0 when no error.
REQ-014 total_cycles  output  32  cycles from leaving IDLE to reaching DONE; saturates at 0xFFFFFFFF.

Function
REQ-015 States: IDLE, LOAD, CONV1, POOL1, CONV2, POOL2, FC, DONE, ERROR.
REQ-016 ctrl is registered: IDLE/DONE/ERROR=0x00; LOAD=0x01, CONV1=0x02, POOL1=0x03, CONV2=0x04, POOL2=0x05, FC=0x06.
REQ-017 IDLE->LOAD when start=1; DONE->LOAD and ERROR->LOAD likewise on start=1.
REQ-018 LOAD->CONV1 when img_ready=1 and return_ctrl=0x01 after the guard window.
REQ-019 Layer state with code k (k=2..6) advances to the next state when return_ctrl equals k after the guard window.
  - CONV1->POOL1->CONV2->POOL2->FC->DONE.
REQ-020 return_ctrl is ignored for exactly GUARD_CYCLES cycles starting on the cycle ctrl first shows the new code; evaluation begins on cycle GUARD_CYCLES+1.
REQ-021 A layer counter clears on every state entry and increments each cycle in LOAD..FC.
  - LOAD is exempt from the watchdog, because it waits on the host.
REQ-022 Watchdog: in CONV1..FC, if the layer counter reaches WDOG_CYCLES before the advance condition holds, go to ERROR.
  - On entry to ERROR: err_layer = current ctrl[2:0] and ctrl = 0x00.
REQ-023 Advance and watchdog on the same cycle: advance wins.
REQ-024 abort=1 in any state: go to IDLE on the next cycle, ctrl=0x00, error and err_layer cleared, total_cycles held.
  - abort has priority over start, advance and watchdog.
REQ-025 total_cycles clears on the LOAD entry, increments each cycle in LOAD..FC, and freezes in DONE/ERROR/IDLE.
REQ-026 start while busy=1 is ignored.
REQ-027 An unexpected return_ctrl value (neither k nor k-1) is treated as not-done; no error is raised.
REQ-028 All outputs are registered; ctrl changes one cycle after the transition condition is sampled.

Reset
REQ-029 On reset, the next-edge state is IDLE:
  - ctrl=0x00, busy=0, done=0, error=0, err_layer=0, total_cycles=0, counters=0.
REQ-030 Reset mid-layer has the same effect as abort, and additionally clears total_cycles.

Structure
REQ-031 A shared package cnn_pkg holds:
  - enum layer_code_t (IDLE=0x00, LOAD=0x01 .. FC=0x06);
  - the sequencer state typedef;
  - WDOG_CYCLES and GUARD_CYCLES defaults.
REQ-032 One sub-module, cnn_seq_timer: the guard/watchdog counter with clear, enable, guard_done and expired outputs; reused for all layers.
REQ-033 The layer controller's return_ctrl feeds this block directly; no re-synchronisation (same clock domain).

Verification
REQ-034 Nominal run: reset, start=1 for 1 cycle, img_ready=1, and a model returning k 10 cycles after ctrl=k.
  - ctrl steps 01,02,03,04,05,06,00.
  - done=1 and total_cycles=66.
REQ-035 Stale done flag: return_ctrl=k+1's prior value (held at k) on the very cycle of a layer entry.
  - No advance until cycle GUARD_CYCLES+1.
REQ-036 Watchdog: WDOG_CYCLES=64 and return_ctrl stuck at 0x03 in CONV2.
  - ERROR 64 cycles after CONV2 entry, err_layer=4, ctrl=0x00.
  - start then returns to LOAD with error=0.
REQ-037 Abort in POOL1 at the same cycle as return_ctrl=0x03: IDLE next cycle, ctrl=0x00, busy=0.
REQ-038 start pulsed during FC: no effect; run completes once with done=1.
REQ-039 Advance and watchdog coincide: return_ctrl=0x06 exactly at counter=WDOG_CYCLES in FC.
  - Result is DONE, not ERROR.
